// File: rtl/steering_pwm_gen.sv
// steering_pwm_gen
//   Turns a joystick X sample into a pair of complementary steering PWM
//   outputs (right/left). Centre deadband, proportional duty scaling, duty
//   slew limiting once per PWM period, and a reversal sequence that always
//   ramps the active side down to zero and passes through IDLE before the
//   other side may be driven.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   en           drive enable; low forces IDLE / zero duty on the next clk
//   x_val        joystick X sample, unsigned, rest value CENTER
//   pwm_right    right-turn PWM, registered
//   pwm_left     left-turn PWM, registered
//   period_start one-clk pulse on the first clk of counter value 0
//   duty_cur     duty currently applied, in PWM count ticks
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | no drive, duty 0; waits for a direction request at a boundary
// DRIVE_R   | right side driven, duty slews toward target
// DRIVE_L   | left side driven, duty slews toward target
// RAMP_DOWN | last driven side (ramp_r) ramps to 0, then back to IDLE
module steering_pwm_gen #(
  parameter int VAL_W     = 10,
  parameter int CNT_W     = 12,
  parameter int PRESC     = 100,
  parameter int PERIOD    = 3000,
  parameter int DUTY_MAX  = 3000,
  parameter int CENTER    = 512,
  parameter int DEADBAND  = 16,
  parameter int SLEW_STEP = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [VAL_W-1:0] x_val,
  output logic             pwm_right,
  output logic             pwm_left,
  output logic             period_start,
  output logic [CNT_W-1:0] duty_cur
);

  localparam int PS_W   = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int PROD_W = VAL_W + CNT_W;

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [VAL_W-1:0] CENTER_V = VAL_W'(CENTER);
  localparam logic [VAL_W-1:0] DB_V     = VAL_W'(DEADBAND);
  localparam logic [CNT_W-1:0] DMAX_V   = CNT_W'(DUTY_MAX);
  localparam logic [CNT_W-1:0] SLEW_V   = CNT_W'(SLEW_STEP);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE_R, S_DRIVE_L, S_RAMP_DOWN} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_RIGHT, DIR_LEFT} dir_t;

  logic [PS_W-1:0]  presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VAL_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] target_q, target_d;
  dir_t             dir_q, dir_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             ramp_r_q, ramp_r_d;
  logic             pwm_right_q, pwm_right_d;
  logic             pwm_left_q, pwm_left_d;
  logic             period_start_q, period_start_d;

  logic              tick, boundary;
  logic [VAL_W-1:0]  diff, mag;
  logic [PROD_W-1:0] prod, scaled;
  logic [CNT_W-1:0]  gap, dn_step, duty_track, duty_ramp, duty_start;
  logic              side_r, side_l;

  // Prescaler and period counter
  always_comb begin
    tick     = (presc_q == PS_LAST);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    boundary = tick && (cnt_q == CNT_LAST);
    cnt_d    = cnt_q;
    if (tick) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Input stage: x_val -> x_q -> target_q/dir_q (two clk of latency)
  always_comb begin
    x_d    = x_val;
    diff   = (x_q > CENTER_V) ? x_q - CENTER_V : CENTER_V - x_q;
    mag    = (diff > DB_V) ? diff - DB_V : '0;
    prod   = PROD_W'(mag) * PROD_W'(DMAX_V);
    scaled = prod >> (VAL_W - 1);
    target_d = (scaled > PROD_W'(DMAX_V)) ? DMAX_V : scaled[CNT_W-1:0];
    if (diff <= DB_V) begin
      dir_d = DIR_NONE;
    end else if (x_q > CENTER_V) begin
      dir_d = DIR_RIGHT;
    end else begin
      dir_d = DIR_LEFT;
    end
  end

  // Slew arithmetic: step toward target, never overshooting it
  always_comb begin
    if (target_q >= duty_q) begin
      gap        = target_q - duty_q;
      duty_track = (gap > SLEW_V) ? duty_q + SLEW_V : target_q;
    end else begin
      gap        = duty_q - target_q;
      duty_track = (gap > SLEW_V) ? duty_q - SLEW_V : target_q;
    end
    dn_step    = (duty_q < SLEW_V) ? duty_q : SLEW_V;
    duty_ramp  = duty_q - dn_step;
    duty_start = (target_q < SLEW_V) ? target_q : SLEW_V;
  end

  // Direction FSM, advanced only on the period boundary
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    ramp_r_d = ramp_r_q;
    if (boundary) begin
      case (state_q)
        S_IDLE: begin
          duty_d = '0;
          if (dir_q == DIR_RIGHT) begin
            state_d = S_DRIVE_R;
            duty_d  = duty_start;
          end else if (dir_q == DIR_LEFT) begin
            state_d = S_DRIVE_L;
            duty_d  = duty_start;
          end
        end
        S_DRIVE_R: begin
          if (dir_q == DIR_RIGHT) begin
            duty_d = duty_track;
          end else begin
            state_d  = S_RAMP_DOWN;
            ramp_r_d = 1'b1;
            duty_d   = duty_ramp;
          end
        end
        S_DRIVE_L: begin
          if (dir_q == DIR_LEFT) begin
            duty_d = duty_track;
          end else begin
            state_d  = S_RAMP_DOWN;
            ramp_r_d = 1'b0;
            duty_d   = duty_ramp;
          end
        end
        S_RAMP_DOWN: begin
          // The opposite side is only ever entered from IDLE.
          duty_d = duty_ramp;
          if (duty_ramp == '0) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          duty_d  = '0;
        end
      endcase
    end
    // Disable overrides everything, including a coincident boundary.
    if (!en) begin
      state_d = S_IDLE;
      duty_d  = '0;
    end
  end

  // Output stage: registered one clk after cnt/state
  always_comb begin
    side_r = (state_q == S_DRIVE_R) || ((state_q == S_RAMP_DOWN) && ramp_r_q);
    side_l = (state_q == S_DRIVE_L) || ((state_q == S_RAMP_DOWN) && !ramp_r_q);
    pwm_right_d    = en && side_r && (cnt_q < duty_q);
    pwm_left_d     = en && side_l && (cnt_q < duty_q);
    period_start_d = boundary;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      x_q            <= '0;
      target_q       <= '0;
      dir_q          <= DIR_NONE;
      state_q        <= S_IDLE;
      duty_q         <= '0;
      ramp_r_q       <= 1'b0;
      pwm_right_q    <= 1'b0;
      pwm_left_q     <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      x_q            <= x_d;
      target_q       <= target_d;
      dir_q          <= dir_d;
      state_q        <= state_d;
      duty_q         <= duty_d;
      ramp_r_q       <= ramp_r_d;
      pwm_right_q    <= pwm_right_d;
      pwm_left_q     <= pwm_left_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_right    = pwm_right_q;
  assign pwm_left     = pwm_left_q;
  assign period_start = period_start_q;
  assign duty_cur     = duty_q;

endmodule

// File: tb/tb_steering_pwm_gen.sv
// tb_steering_pwm_gen
//   Directed bench for steering_pwm_gen with a short PWM period
//   (PRESC=1, PERIOD=100, DUTY_MAX=100, SLEW_STEP=25). The stimulus process
//   pushes one expected record per PWM period (duty, right-high clocks,
//   left-high clocks); a monitor integrates the outputs over each period
//   delimited by period_start and compares against the popped record.
module tb_steering_pwm_gen;

  localparam int VAL_W  = 10;
  localparam int CNT_W  = 12;
  localparam int PERIOD = 100;

  logic             clk;
  logic             rst;
  logic             en;
  logic [VAL_W-1:0] x_val;
  logic             pwm_right;
  logic             pwm_left;
  logic             period_start;
  logic [CNT_W-1:0] duty_cur;

  steering_pwm_gen #(
    .VAL_W(VAL_W), .CNT_W(CNT_W), .PRESC(1), .PERIOD(PERIOD),
    .DUTY_MAX(100), .CENTER(512), .DEADBAND(16), .SLEW_STEP(25)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .x_val(x_val),
    .pwm_right(pwm_right), .pwm_left(pwm_left),
    .period_start(period_start), .duty_cur(duty_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    bit chk;
    int duty;
    int rh;
    int lh;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int id, input bit c, input int d, input int r, input int l);
    exp_t e;
    e.id = id; e.chk = c; e.duty = d; e.rh = r; e.lh = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_ps(input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!period_start && waited < budget);
    if (!period_start) begin
      n_vec++;
      n_err++;
      $display("FAIL ps_timeout: no period_start after %0d clk, expected within %0d", waited, budget);
    end
  endtask

  // Monitor: one period = the PERIOD samples following a period_start sample
  exp_t cur;
  bit   mon_active = 0;
  bit   ps_prev    = 0;
  int   rcnt = 0, lcnt = 0, ovl = 0;
  int   duty_latched = 0, duty_at_start = 0;

  always @(negedge clk) begin
    if (!rst) begin
      mon_active = 0;
      ps_prev    = 0;
    end else begin
      if (ps_prev) begin
        if (mon_active) begin
          check($sformatf("p%0d_overlap", cur.id), ovl, 0);
          if (cur.chk) begin
            check($sformatf("p%0d_duty", cur.id), duty_at_start, cur.duty);
            check($sformatf("p%0d_right_high", cur.id), rcnt, cur.rh);
            check($sformatf("p%0d_left_high", cur.id), lcnt, cur.lh);
          end
        end
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          mon_active = 1;
        end else begin
          mon_active = 0;
        end
        rcnt = 0; lcnt = 0; ovl = 0;
        duty_at_start = duty_latched;
      end
      if (mon_active) begin
        rcnt += int'(pwm_right);
        lcnt += int'(pwm_left);
        if (pwm_right && pwm_left) ovl++;
      end
      if (period_start) duty_latched = int'(duty_cur);
      ps_prev = period_start;
    end
  end

  initial begin
    int n;
    rst   = 1'b0;
    en    = 1'b1;
    x_val = 10'd1023;
    repeat (10) @(negedge clk);
    check("rst_pwm_right", int'(pwm_right), 0);
    check("rst_pwm_left", int'(pwm_left), 0);
    check("rst_duty", int'(duty_cur), 0);
    check("rst_period_start", int'(period_start), 0);

    // Full right: slew 25 per period up to target 96
    push(1, 1, 25, 25, 0);
    push(2, 1, 50, 50, 0);
    push(3, 1, 75, 75, 0);
    push(4, 1, 96, 96, 0);
    push(5, 1, 96, 96, 0);
    rst = 1'b1;
    wait_ps(200, n);
    check("first_ps_latency", n, PERIOD);
    repeat (4) wait_ps(150, n);

    // Reversal: ramp right down, IDLE, then ramp left up
    x_val = 10'd0;
    push(6, 1, 71, 71, 0);
    push(7, 1, 46, 46, 0);
    push(8, 1, 21, 21, 0);
    push(9, 1, 0, 0, 0);
    push(10, 1, 25, 0, 25);
    push(11, 1, 50, 0, 50);
    push(12, 1, 75, 0, 75);
    push(13, 1, 96, 0, 96);
    repeat (8) wait_ps(150, n);

    // Inside deadband: left ramps down then stays at zero
    x_val = 10'd520;
    push(14, 1, 71, 0, 71);
    push(15, 1, 46, 0, 46);
    push(16, 1, 21, 0, 21);
    push(17, 1, 0, 0, 0);
    push(18, 1, 0, 0, 0);
    push(19, 1, 0, 0, 0);
    repeat (6) wait_ps(150, n);

    // Just outside deadband: mag 12 -> target 2
    x_val = 10'd540;
    push(20, 1, 2, 2, 0);
    push(21, 1, 2, 2, 0);
    repeat (2) wait_ps(150, n);

    x_val = 10'd520;
    push(22, 1, 0, 0, 0);
    push(23, 1, 0, 0, 0);
    push(24, 1, 0, 0, 0);
    repeat (3) wait_ps(150, n);

    x_val = 10'd1023;
    push(25, 1, 25, 25, 0);
    push(26, 1, 50, 50, 0);
    push(27, 0, 0, 0, 0);
    repeat (3) wait_ps(150, n);

    // Disable in the middle of a 75-tick high pulse
    repeat (10) @(negedge clk);
    check("en_pre_pwm_right", int'(pwm_right), 1);
    check("en_pre_duty", int'(duty_cur), 75);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("en_off_pwm_right", int'(pwm_right), 0);
    check("en_off_pwm_left", int'(pwm_left), 0);
    check("en_off_duty", int'(duty_cur), 0);
    wait_ps(150, n);
    check("en_off_duty_at_ps", int'(duty_cur), 0);
    en = 1'b1;
    push(28, 0, 0, 0, 0);
    push(29, 1, 25, 25, 0);
    push(30, 0, 0, 0, 0);
    repeat (2) wait_ps(150, n);

    // Asynchronous reset in the middle of a 50-tick high pulse
    repeat (10) @(negedge clk);
    check("ar_pre_pwm_right", int'(pwm_right), 1);
    check("ar_pre_duty", int'(duty_cur), 50);
    #1 rst = 1'b0;
    #1;
    check("ar_async_pwm_right", int'(pwm_right), 0);
    check("ar_async_duty", int'(duty_cur), 0);
    repeat (3) @(negedge clk);
    push(31, 1, 25, 25, 0);
    push(32, 1, 50, 50, 0);
    rst = 1'b1;
    wait_ps(200, n);
    check("ar_restart_ps_latency", n, PERIOD);
    repeat (2) wait_ps(150, n);
    repeat (2) @(negedge clk);
    check("records_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/steering_pwm_gen.md
Name: steering_pwm_gen

Overview:
- Parametrised successor to the rear-wheel X-axis steering block.
- Converts a joystick axis sample into two complementary PWM outputs (right/left).
- Adds over the previous generation: configurable period and resolution, centre deadband, proportional duty scaling, per-period slew limiting, and a safe direction-reversal state machine.
- Sits between the JSTK2 SPI decoder and the motor driver pins. Contains its own prescaler and period counter.

Parameters:
- VAL_W, 10, width of the joystick sample.
- CNT_W, 12, width of the period counter and duty registers.
- PRESC, 100, clk cycles per PWM count tick (1 us at 100 MHz).
- PERIOD, 3000, ticks per PWM period (3 ms); must be < 2**CNT_W.
- DUTY_MAX, 3000, duty saturation value; must be ≤ PERIOD.
- CENTER, 512, joystick rest value.
- DEADBAND, 16, half-width of the zero zone around CENTER.
- SLEW_STEP, 100, maximum duty change per period.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset.
- en, input, 1, drive enable; low forces safe stop.
- x_val, input, VAL_W, joystick X sample, unsigned.
- pwm_right, output, 1, right-turn PWM, registered.
- pwm_left, output, 1, left-turn PWM, registered.
- period_start, output, 1, one-clk pulse coincident with counter value 0.
- duty_cur, output, CNT_W, currently applied duty, for debug/verification.

Behaviour:
- Reset (rst=0, asynchronous):
  - prescaler = 0, cnt = 0, duty_cur = 0, state = IDLE.
  - pwm_right = 0, pwm_left = 0, period_start = 0.
- Prescaler:
  - Counts 0..PRESC-1.
  - tick = 1 on the clk where prescaler == PRESC-1.
  - PRESC=1 gives tick every clk.
- Period counter:
  - cnt increments on tick and wraps PERIOD-1 -> 0.
  - boundary = tick && cnt == PERIOD-1.
- Input stage: x_val is registered each clk (x_q). A registered target (target_q) is computed from x_q, giving 2 clk of latency. x_val must therefore be stable ≥3 clk before a boundary to take effect.
- Target computation:
  - diff = |x_q - CENTER|.
  - mag = diff - DEADBAND if diff > DEADBAND, else 0.
  - target = min((mag * DUTY_MAX) >> (VAL_W-1), DUTY_MAX); intermediate width ≥ VAL_W + CNT_W, no overflow.
  - dir_req = RIGHT if x_q > CENTER+DEADBAND; LEFT if x_q < CENTER-DEADBAND; NONE otherwise (target = 0).
- FSM, evaluated only on boundary; duty_cur changes only on boundary:
  - IDLE: duty_cur = 0.
    - dir_req RIGHT -> DRIVE_R, duty_cur = min(target, SLEW_STEP).
    - dir_req LEFT -> DRIVE_L, likewise.
  - DRIVE_R / DRIVE_L, same direction requested: duty_cur steps toward target by at most SLEW_STEP, landing exactly on target when within a step.
  - DRIVE_R / DRIVE_L, opposite direction or NONE requested: -> RAMP_DOWN, duty_cur -= min(duty_cur, SLEW_STEP).
  - RAMP_DOWN:
    - Decrements by SLEW_STEP each boundary.
    - On reaching 0 -> IDLE.
    - Re-entry into a drive state happens from IDLE at the next boundary, never directly.
    - ramp_dir holds the last driven side.
  - en = 0 at any clk: state -> IDLE and duty_cur -> 0 on the next clk (not waiting for a boundary); both outputs low on the next clk. Counter and prescaler keep running.
- Outputs, registered, 1 clk after cnt/state:
  - pwm_right = (state == DRIVE_R, or RAMP_DOWN with ramp_dir = R) && cnt < duty_cur && en.
  - pwm_left: symmetric.
  - pwm_right and pwm_left are never both 1.
  - duty_cur = 0 gives a constant low output.
  - duty_cur = PERIOD gives a constant high output.
- period_start: registered pulse, high for exactly 1 clk per period, aligned with the first clk of cnt == 0.
- Simultaneous en low and boundary: en wins, so duty_cur = 0.
- Reset mid-period: outputs drop low asynchronously. The first period after release starts at cnt = 0.

Test Plan:
- Reset with x_val=1023, rst held low 10 clk -> pwm_right = pwm_left = 0, duty_cur = 0. After release, period_start first pulses PRESC*PERIOD clk later (300000 clk at defaults).
- Params PRESC=1, PERIOD=100, DUTY_MAX=100, SLEW_STEP=25; x_val=1023 -> mag 495, target 96. duty_cur per period = 25, 50, 75, 96, 96. pwm_right high exactly duty_cur clk per period; pwm_left always 0.
- Same params, steady at 96 right, then x_val=0 (target 96 left) -> duty_cur 71, 46, 21, 0 with pwm_right only, then IDLE. Next periods: pwm_left duty 25, 50, 75, 96. No overlap at any clk.
- Deadband, same params: x_val=520 -> duty 0, both outputs low. x_val=540 -> mag 12, target 2, pwm_right high 2 clk per period.
- en deasserted mid-period while duty_cur=75 -> both outputs low within 2 clk, duty_cur=0. Re-enabling with x_val=1023 ramps from 25.
- Async reset asserted mid-high pulse -> output low without a clock edge. After release, counter restarts at 0 and the FSM is in IDLE.
